tdm_demux16: RTL

//  Receive end of the 16-channel time-division link. The transmit side scans a
//  16:1 mux select 0..15 and drives one bit per slot onto a serial wire.

---
 rtl/tdm_pkg.sv | 15 +
 rtl/tdm_chan_counter.sv | 38 +++
 rtl/tdm_demux16.sv | 104 ++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the 16-channel TDM link.
// The transmit-side scanner and the receive-side demux both import this package.
package tdm_pkg;

  localparam int N_CH    = 16;
  localparam int SEL_W   = $clog2(N_CH);
  // Channel index that the frame-sync marker tags.
  localparam int SYNC_CH = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : tdm_pkg

// File: rtl/tdm_chan_counter.sv
// Slot counter for the TDM receiver. It wraps modulo N_CH. load1_i restarts it
// at the slot after the sync channel. last_o flags the final slot of a frame.
module tdm_chan_counter
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             load1_i,
  output logic [SEL_W-1:0] count_o,
  output logic             last_o
);

  logic [SEL_W-1:0] count_q;
  logic [SEL_W-1:0] count_d;

  // Next count: restart has priority over increment; wrap after the last slot.
  always_comb begin
    // NOTE: assign every combinational output a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (load1_i) begin
      count_d = SEL_W'(SYNC_CH + 1);
    end else if (en_i) begin
      count_d = last_o ? '0 : count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking (<=) in clocked blocks so every flop samples pre-edge values.
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;
  assign last_o  = (count_q == SEL_W'(N_CH - 1));

endmodule : tdm_chan_counter

// File: rtl/tdm_demux16.sv
// Receive end of the 16-channel TDM link. Serial slots are de-serialised into
// a shadow register, keyed by sync on channel 0. Each complete word is published
// to dout in one step, with a one-cycle frame_valid strobe.
module tdm_demux16
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [N_CH-1:0]  dout,
  output logic             frame_valid,
  output logic [SEL_W-1:0] ch_idx,
  output logic             locked,
  output logic             sync_err
);

  state_e            state_q, state_d;
  logic [N_CH-1:0]   shadow_q, shadow_d;
  logic [N_CH-1:0]   dout_q, dout_d;
  logic              fv_q, fv_d;
  logic              serr_q, serr_d;
  logic              cnt_en, cnt_load1;
  logic [SEL_W-1:0]  cnt;
  logic              cnt_last;
  logic              sync_acc;

  // sync only counts on a cycle that actually carries a slot.
  assign sync_acc = din_valid & sync;

  tdm_chan_counter u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (cnt_en),
    .load1_i (cnt_load1),
    .count_o (cnt),
    .last_o  (cnt_last)
  );

  // Frame FSM: decide the next state, shadow/output updates and the counter controls.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    dout_d    = dout_q;
    fv_d      = 1'b0;
    serr_d    = 1'b0;
    cnt_en    = 1'b0;
    cnt_load1 = 1'b0;
    case (state_q)
      IDLE: begin
        // Slots seen before the first sync are discarded.
        if (sync_acc) begin
          shadow_d          = '0;
          shadow_d[SYNC_CH] = din;
          cnt_load1         = 1'b1;
          state_d           = RUN;
        end
      end
      RUN: begin
        if (sync_acc) begin
          // A sync anywhere but channel 0 means the partial frame is lost. Restart it.
          serr_d            = (cnt != SEL_W'(SYNC_CH));
          shadow_d          = '0;
          shadow_d[SYNC_CH] = din;
          cnt_load1         = 1'b1;
        end else if (din_valid) begin
          shadow_d[cnt] = din;
          cnt_en        = 1'b1;
          if (cnt_last) begin
            dout_d = {din, shadow_q[N_CH-2:0]};
            fv_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      // NOTE: the shadow word is reset too, so a frame never carries stale bits out of reset.
      shadow_q <= '0;
      dout_q   <= '0;
      fv_q     <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      fv_q     <= fv_d;
      serr_q   <= serr_d;
    end
  end

  assign dout        = dout_q;
  assign frame_valid = fv_q;
  assign ch_idx      = cnt;
  assign locked      = (state_q == RUN);
  assign sync_err    = serr_q;

endmodule : tdm_demux16
